// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int unsigned DEF_LINES = 16;
    localparam int unsigned DEF_WORDS = 4;
    localparam int unsigned XLEN      = 32;

    // Offset / index / tag widths for the default geometry
    localparam int unsigned OB = $clog2(DEF_WORDS);
    localparam int unsigned IB = $clog2(DEF_LINES);
    localparam int unsigned TB = XLEN - OB - IB - 2;

    localparam logic [XLEN-1:0] NOP = 32'h0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Word-read handshake between the instruction cache and main memory.
interface inst_cache_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: one combinational read port, one write port.
module inst_cache_array #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TW    = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    input  logic [$clog2(WORDS)-1:0] rd_word,
    output logic                     rd_valid,
    output logic [TW-1:0]            rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic                     set_valid,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic [$clog2(WORDS)-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic [TW-1:0]            wr_tag
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [TW-1:0]    tag_d  [LINES];
    logic [31:0]      data_q [LINES][WORDS];
    logic [31:0]      data_d [LINES][WORDS];

    // Flush wins over a same-cycle line completion
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_word] = wr_data;
        end
        if (set_valid) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until their line is valid
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with zero-latency hits and
// word-by-word line refill from main memory.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [31:0]        pc,
    input  logic               flush,
    output logic [31:0]        instr,
    output logic               ihit,
    inst_cache_if.master       mem
);

    localparam int unsigned OW = $clog2(WORDS);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 32 - OW - IW - 2;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [OW-1:0]   cnt_q, cnt_d;

    logic [OW-1:0]   pc_word;
    logic [IW-1:0]   pc_idx;
    logic [TW-1:0]   pc_tag;
    logic [31:0]     pc_line;
    logic            rd_valid;
    logic [TW-1:0]   rd_tag;
    logic [31:0]     rd_data;
    logic            hit_c, last_ack_c, wr_en, fill_done;

    assign pc_word    = pc[OW+1:2];
    assign pc_idx     = pc[IW+OW+1:OW+2];
    assign pc_tag     = pc[31:IW+OW+2];
    assign pc_line    = pc & ~32'(WORDS * 4 - 1);
    assign hit_c      = rd_valid && (rd_tag == pc_tag) && !flush;
    assign last_ack_c = mem.mem_ack && (cnt_q == OW'(WORDS - 1));

    inst_cache_array #(.LINES(LINES), .WORDS(WORDS), .TW(TW)) u_array (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .rd_idx    (pc_idx),
        .rd_word   (pc_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .set_valid (fill_done),
        .wr_idx    (mem_addr_q[IW+OW+1:OW+2]),
        .wr_word   (cnt_q),
        .wr_data   (mem.mem_rdata),
        .wr_tag    (mem_addr_q[31:IW+OW+2])
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!hit_c && !flush)        state_d = FILL;
            FILL: if (flush || last_ack_c)     state_d = IDLE;
        endcase
    end

    // The fill address also carries the line being written (index/tag bits)
    always_comb begin
        ihit       = 1'b0;
        instr      = NOP;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                ihit = hit_c;
                if (hit_c) begin
                    instr = rd_data;
                end else if (!flush) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_line;
                    cnt_d      = '0;
                end
            end
            FILL: begin
                if (flush) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end else if (mem.mem_ack) begin
                    wr_en      = 1'b1;
                    cnt_d      = cnt_q + OW'(1);
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (last_ack_c) begin
                        fill_done = 1'b1;
                        mem_req_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache that answers the PC register's fetch address on the same cycle. It returns `instr` and `ihit`; the PC register advances only on `ihit`. On a miss it refills the whole line, one word at a time, from main memory over a req/ack handshake, then reports a hit.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pc`  in  32  fetch byte address from the PC register; bits [1:0] ignored.
- `flush`  in  1  synchronous invalidate of all lines.
- `instr`  out  32  fetched instruction; 32'h0 whenever `ihit`=0.
- `ihit`  out  1  `instr` valid for current `pc`.
- `mem_req`  out  1  word read request to main memory (registered).
- `mem_addr`  out  32  word-aligned byte address of requested word (registered).
- `mem_ack`  in  1  memory accepts request and presents `mem_rdata` this cycle.
- `mem_rdata`  in  32  read data, valid only with `mem_ack`.

## Operation
- Address split: word = pc[OB+1:2], index = next log2(LINES) bits, tag = remaining upper bits, where OB = log2(WORDS). Defaults: word pc[3:2], index pc[7:4], tag pc[31:8].
- Per line: valid bit, tag, and WORDS data words. Only valid bits are reset; tag and data contents are don't-care until written.
- States: IDLE, FILL.
- IDLE:
  - `ihit` = valid[index] && tag match && !flush; combinational from `pc`.
  - On a miss, latch the line base (pc with word and byte bits zeroed), clear the word counter, and go to FILL. `mem_req` becomes 1 and `mem_addr` the line base.
- FILL:
  - `ihit` = 0.
  - `mem_req` and `mem_addr` stay stable until a cycle with `mem_ack`=1.
  - On ack: write `mem_rdata` into word[counter] of the latched line; counter+1; `mem_addr`+4.
  - On the ack of word WORDS-1: write tag, set valid, drop `mem_req`, return to IDLE.
  - The fill ignores `pc` changes; lookup resumes against the current `pc` in IDLE.
- `mem_ack` is ignored outside FILL.
- `flush` clears all valid bits.
  - In FILL, flush aborts the fill: go to IDLE, drop `mem_req`.
  - Flush coincident with the final ack leaves the line invalid.
- Reset: state IDLE, all valid=0, `mem_req`=0, `mem_addr`=0, counter=0. So `ihit`=0 and `instr`=0 while `rstn` is low.
- Reset asserted mid-fill drops `mem_req` immediately (asynchronously); the partial line is discarded.

## Timing
- Hit latency: 0 cycles. `instr`/`ihit` are valid in the same cycle as `pc`, for the PC register to sample at the next posedge.
- Miss penalty with zero-wait memory (ack in the request cycle), WORDS=4:
  - cycle 0: miss detected;
  - cycles 1–4: `mem_req`=1 with addresses base, +4, +8, +12;
  - cycle 5: IDLE, `ihit`=1 if `pc` is unchanged.
- Each memory wait cycle adds one cycle.
- `mem_req` never deasserts between words of one fill.

## Structure
- Package `inst_cache_pkg`:
  - state encoding (IDLE, FILL);
  - localparams OB, IB, TB (offset/index/tag widths) derived from LINES/WORDS;
  - NOP constant 32'h0.
- Sub-module `inst_cache_array`:
  - tag/valid/data storage;
  - one combinational read port (index, word);
  - one write port (index, word, data, tag/valid update);
  - synchronous flush clear; asynchronous reset of valid bits.
- Top: FSM, counter, address split, memory handshake.

## Test plan
- Cold miss: reset, pc=0x40, memory acks immediately with data 0x11,0x22,0x33,0x44 -> mem_addr 0x40,0x44,0x48,0x4C on cycles 1–4; cycle 5 ihit=1, instr=0x11.
- Hit: after the cold fill, pc=0x48 -> ihit=1, instr=0x33 in the same cycle, no mem_req.
- Conflict: pc=0x140 (index 4, different tag) -> miss and refill; then pc=0x40 -> miss again.
- Slow memory: ack after 3 wait cycles per word -> mem_req and mem_addr stable across the waits; ihit on cycle 1+4×4=17.
- Reset mid-fill: rstn low after 2 acks -> mem_req=0 and ihit=0 immediately; after release, pc=0x40 misses and refill restarts at 0x40.
- Flush with final ack: flush=1 on the 4th ack -> next cycle IDLE, ihit=0, new fill starts from 0x40.
